// File: rtl/frame_link_rx_if.sv
// Decoder, Encoder and host-side signals of the frame receiver.
// master = surrounding link and host, slave = the receiver.
interface frame_link_rx_if #(
   parameter int N_PKT     = 8,
   parameter int FRAME_LEN = 4
);
   logic [N_PKT-1:0]           dec_data;
   logic                       dec_avail;
   logic                       dec_error;
   logic                       dec_read;
   logic [N_PKT-1:0]           enc_data;
   logic                       enc_start;
   logic                       enc_avail;
   logic [FRAME_LEN*N_PKT-1:0] frame_data;
   logic                       frame_valid;
   logic                       frame_ready;
   logic [2:0]                 err_code;
   logic [15:0]                frame_cnt;

   // Host port: a frame transfers on every clock edge where frame_valid and frame_ready
   // are both 1; frame_valid stays high and frame_data stays stable until that edge.
   modport master (
      output dec_data, dec_avail, dec_error, enc_avail, frame_ready,
      input  dec_read, enc_data, enc_start, frame_data, frame_valid, err_code, frame_cnt
   );

   modport slave (
      input  dec_data, dec_avail, dec_error, enc_avail, frame_ready,
      output dec_read, enc_data, enc_start, frame_data, frame_valid, err_code, frame_cnt
   );
endinterface

// File: rtl/frame_link_rx.sv
// Multi-packet frame receiver: hunts for SOF, collects payload and checksum from the
// Decoder, answers ACK/NAK through the Encoder and hands good frames to the host.
module frame_link_rx #(
   parameter int               N_PKT     = 8,
   parameter int               FRAME_LEN = 4,
   parameter logic [N_PKT-1:0] SOF_PKT   = 8'h7E,
   parameter logic [N_PKT-1:0] ACK_PKT   = 8'h06,
   parameter logic [N_PKT-1:0] NAK_PKT   = 8'h15,
   parameter int               TIMEOUT   = 200000
) (
   input  logic           clk,
   input  logic           rst_n,
   frame_link_rx_if.slave bus,
   output logic [2:0]     state_dbg
);
   localparam int FW = FRAME_LEN * N_PKT;
   localparam int GW = $clog2(TIMEOUT + 1);
   localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [GW-1:0] GAP_MAX  = GW'(TIMEOUT);
   localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      HUNT     = 3'd0,
      PAYLOAD  = 3'd1,
      CHECK    = 3'd2,
      REPLY    = 3'd3,
      WAIT_ENC = 3'd4
   } state_t;

   state_t           state;
   logic [N_PKT-1:0] pkt;
   logic             pkt_err;
   logic [FW-1:0]    frame_buf;
   logic [N_PKT-1:0] sum;
   logic [IW-1:0]    idx;
   logic [GW-1:0]    gap;
   logic             reply_ack;
   logic             enc_low;
   logic             in_frame;
   logic             rd_ok;
   logic             host_free;

   // A packet captured on the rd_ok edge is acted on one edge later, while dec_read is high.
   assign in_frame  = (state == PAYLOAD) || (state == CHECK);
   assign rd_ok     = bus.dec_avail && !bus.dec_read && (in_frame || state == HUNT);
   assign host_free = !bus.frame_valid || bus.frame_ready;
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= HUNT;
         pkt             <= '0;
         pkt_err         <= 1'b0;
         frame_buf       <= '0;
         sum             <= '0;
         idx             <= '0;
         gap             <= '0;
         reply_ack       <= 1'b0;
         enc_low         <= 1'b0;
         bus.dec_read    <= 1'b0;
         bus.enc_data    <= '0;
         bus.enc_start   <= 1'b0;
         bus.frame_data  <= '0;
         bus.frame_valid <= 1'b0;
         bus.err_code    <= 3'd0;
         bus.frame_cnt   <= 16'd0;
      end else begin
         bus.dec_read  <= rd_ok;
         bus.enc_start <= 1'b0;
         if (rd_ok) begin
            pkt     <= bus.dec_data;
            pkt_err <= bus.dec_error;
         end
         if (rd_ok || !in_frame)
            gap <= '0;
         else if (gap != GAP_MAX)
            gap <= gap + 1'b1;
         // A load in CHECK below overrides this release when both happen on one edge.
         if (bus.frame_valid && bus.frame_ready)
            bus.frame_valid <= 1'b0;

         case (state)
            HUNT: begin
               if (bus.dec_read && !pkt_err && pkt == SOF_PKT) begin
                  state <= PAYLOAD;
                  idx   <= '0;
                  sum   <= '0;
               end
            end
            PAYLOAD: begin
               if (bus.dec_read) begin
                  if (pkt_err) begin
                     bus.err_code <= 3'd1;
                     reply_ack    <= 1'b0;
                     state        <= REPLY;
                  end else begin
                     frame_buf[idx*N_PKT +: N_PKT] <= pkt;
                     sum <= sum + pkt;
                     idx <= idx + 1'b1;
                     if (idx == IDX_LAST)
                        state <= CHECK;
                  end
               end else if (gap == GAP_MAX) begin
                  bus.err_code <= 3'd2;
                  state        <= HUNT;
               end
            end
            CHECK: begin
               if (bus.dec_read) begin
                  state     <= REPLY;
                  reply_ack <= 1'b0;
                  if (pkt_err) begin
                     bus.err_code <= 3'd1;
                  end else if (pkt != sum) begin
                     bus.err_code <= 3'd3;
                  end else if (host_free) begin
                     bus.frame_data  <= frame_buf;
                     bus.frame_valid <= 1'b1;
                     bus.frame_cnt   <= bus.frame_cnt + 16'd1;
                     bus.err_code    <= 3'd0;
                     reply_ack       <= 1'b1;
                  end else begin
                     bus.err_code <= 3'd4;
                  end
               end else if (gap == GAP_MAX) begin
                  bus.err_code <= 3'd2;
                  state        <= HUNT;
               end
            end
            REPLY: begin
               if (bus.enc_avail) begin
                  bus.enc_start <= 1'b1;
                  bus.enc_data  <= reply_ack ? ACK_PKT : NAK_PKT;
                  enc_low       <= 1'b0;
                  state         <= WAIT_ENC;
               end
            end
            WAIT_ENC: begin
               // The Encoder must be seen busy once before its return to idle ends the reply.
               if (!bus.enc_avail)
                  enc_low <= 1'b1;
               else if (enc_low)
                  state <= HUNT;
            end
            default: state <= HUNT;
         endcase
      end
   end
endmodule

// File: tb/tb_frame_link_rx.sv
// Bench for frame_link_rx: vector table, timeout/overflow/same-cycle/reset sequences,
// and random frames scored against a packet-list reference model.
module tb_frame_link_rx;
   localparam int         N_PKT     = 8;
   localparam int         FRAME_LEN = 4;
   localparam int         TIMEOUT   = 40;
   localparam int         W         = FRAME_LEN * N_PKT;
   localparam logic [7:0] SOF       = 8'h7E;
   localparam logic [7:0] ACK       = 8'h06;
   localparam logic [7:0] NAK       = 8'h15;
   localparam int         NONE      = -1;

   typedef struct {
      logic [63:0]  pk;   // packet 0 in the top byte
      logic [7:0]   em;   // dec_error per packet, bit i = packet i
      int           n;
      int           rep;
      logic [2:0]   err;
      logic [W-1:0] fr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] state_dbg;
   int         n_vec = 0;
   int         n_err = 0;
   int         host_mode = 1;   // 0 hold off, 1 always ready, 2 random
   logic       rnd_ready = 1'b0;
   logic [15:0] exp_cnt;
   logic [2:0] last_err;
   logic [W-1:0] exp_q[$];
   logic [7:0] rep_q[$];
   vec_t       tbl[7];

   frame_link_rx_if #(.N_PKT(N_PKT), .FRAME_LEN(FRAME_LEN)) bus();

   frame_link_rx #(.N_PKT(N_PKT), .FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / host ready ----------------
   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1 rnd_ready = 1'($urandom_range(0, 1));
   end

   assign bus.frame_ready = (host_mode == 2) ? rnd_ready : (host_mode == 1);

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void ref_frame(input logic [7:0] d[$], input logic e[$], output int rep,
                                     output logic [2:0] err, output logic [W-1:0] frame,
                                     output int used);
      int k;
      int sum;
      k = 0;
      sum = 0;
      rep = NONE;
      err = 3'd0;
      frame = '0;
      used = d.size();
      while (k < d.size() && (e[k] || d[k] != SOF)) k++;
      k++;
      for (int p = 0; p <= FRAME_LEN; p++) begin
         if (k >= d.size()) return;
         if (e[k]) begin
            rep = int'(NAK); err = 3'd1; used = k + 1;
            return;
         end
         if (p == FRAME_LEN) begin
            if (int'(d[k]) == sum % (2 ** N_PKT)) begin
               rep = int'(ACK); err = 3'd0;
            end else begin
               rep = int'(NAK); err = 3'd3;
            end
            used = k + 1;
            return;
         end
         frame[p*N_PKT +: N_PKT] = d[k];
         sum += int'(d[k]);
         k++;
      end
   endfunction

   // ---------------- Encoder model ----------------
   initial begin
      logic [7:0] held;
      bus.enc_avail = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.enc_start === 1'b1) begin
            chk("enc_start_while_avail", {31'd0, bus.enc_avail}, 32'd1);
            rep_q.push_back(bus.enc_data);
            held = bus.enc_data;
            bus.enc_avail = 1'b0;
            repeat ($urandom_range(2, 5)) begin
               @(negedge clk);
               chk("enc_data_hold", {24'd0, bus.enc_data}, {24'd0, held});
            end
            bus.enc_avail = 1'b1;
         end
      end
   end

   // ---------------- host scoreboard and dec_read pulse check ----------------
   initial forever begin
      @(negedge clk);
      if (rst_n && bus.frame_valid && bus.frame_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_data: got unexpected frame %0h, expected none", bus.frame_data);
         end else begin
            chk("frame_data", bus.frame_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.dec_read === 1'b1) chk("dec_read_single", {31'd0, prev}, 32'd0);
         prev = bus.dec_read;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_pkt(input logic [7:0] d, input logic e, input int gap);
      int n;
      n = 0;
      repeat (gap) begin @(posedge clk); #1; end
      bus.dec_data = d;
      bus.dec_error = e;
      bus.dec_avail = 1'b1;
      do begin @(posedge clk); #1; n++; end while (bus.dec_read !== 1'b1 && n < 400);
      if (bus.dec_read !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL dec_read: no pulse for packet %02h in %0d cycles, expected one", d, n);
      end
      bus.dec_avail = 1'b0;
   endtask

   task automatic check_reply(input int rep, input string tag);
      int n;
      n = 0;
      if (rep == NONE) begin
         repeat (10) @(posedge clk);
         #1 chk({tag, "_no_reply"}, rep_q.size(), 0);
      end else begin
         while (rep_q.size() == 0 && n < 400) begin @(posedge clk); #1; n++; end
         if (rep_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_reply: no enc_start in %0d cycles, expected %02h", tag, n, rep);
         end else begin
            chk({tag, "_reply"}, {24'd0, rep_q.pop_front()}, rep);
         end
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (n < 400 && !(bus.frame_valid === 1'b0 && state_dbg == 3'd0 && bus.enc_avail))
         begin @(posedge clk); #1; n++; end
      if (n >= 400) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_idle: frame_valid=%0b state=%0d, expected 0/0", tag, bus.frame_valid, state_dbg);
      end
   endtask

   task automatic run_frame(input logic [7:0] d[$], input logic e[$], input int n, input int rep,
                            input logic [2:0] err, input logic [W-1:0] fr, input bit late_ready,
                            input string tag);
      if (rep == int'(ACK)) begin
         exp_q.push_back(fr);
         exp_cnt++;
      end
      for (int i = 0; i < n; i++) begin
         send_pkt(d[i], e[i], $urandom_range(0, 2));
         if (late_ready && i == n - 1) host_mode = 1;
      end
      check_reply(rep, tag);
      chk({tag, "_err_code"}, {29'd0, bus.err_code}, {29'd0, err});
      chk({tag, "_frame_cnt"}, {16'd0, bus.frame_cnt}, {16'd0, exp_cnt});
      last_err = err;
   endtask

   task automatic row_q(input vec_t v, output logic [7:0] d[$], output logic e[$]);
      d = {};
      e = {};
      for (int i = 0; i < 8; i++) begin
         d.push_back(v.pk[63-8*i -: 8]);
         e.push_back(v.em[i]);
      end
   endtask

   task automatic rand_frame(input int idx);
      logic [7:0]   d[$];
      logic         e[$];
      logic [7:0]   s;
      logic [7:0]   v;
      logic [W-1:0] fr;
      logic [2:0]   err;
      int           rep;
      int           used;
      int           kind;
      s = 8'd0;
      repeat ($urandom_range(0, 2)) begin
         d.push_back(8'($urandom_range(0, 8'h7D)));
         e.push_back(1'($urandom_range(0, 1)));
      end
      d.push_back(SOF);
      e.push_back(1'b0);
      for (int p = 0; p < FRAME_LEN; p++) begin
         v = 8'($urandom);
         d.push_back(v);
         e.push_back(1'b0);
         s = s + v;
      end
      d.push_back(s);
      e.push_back(1'b0);
      kind = $urandom_range(0, 3);
      if (kind == 1) d[d.size()-1] = s + 8'($urandom_range(1, 255));
      else if (kind == 2) e[d.size() - 1 - $urandom_range(0, FRAME_LEN)] = 1'b1;
      ref_frame(d, e, rep, err, fr, used);
      run_frame(d, e, used, rep, err, fr, 1'b0, $sformatf("rand%0d", idx));
      wait_idle($sformatf("rand%0d", idx));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] d[$];
      logic       e[$];
      bus.dec_avail = 1'b0;
      bus.dec_data  = 8'd0;
      bus.dec_error = 1'b0;
      exp_cnt  = 16'd0;
      last_err = 3'd0;
      tbl[0] = '{64'h7E01_0203_040A_0000, 8'h00, 6, int'(ACK), 3'd0, 32'h04030201};
      tbl[1] = '{64'h7E01_0203_040B_0000, 8'h00, 6, int'(NAK), 3'd3, 32'h0};
      tbl[2] = '{64'h7E01_0203_0000_0000, 8'h08, 4, int'(NAK), 3'd1, 32'h0};
      tbl[3] = '{64'h557E_1020_3040_A000, 8'h00, 7, int'(ACK), 3'd0, 32'h40302010};
      tbl[4] = '{64'h7E7E_FFFF_FFFF_FC00, 8'h01, 7, int'(ACK), 3'd0, 32'hFFFFFFFF};
      tbl[5] = '{64'h7E11_2233_44AA_0000, 8'h20, 6, int'(NAK), 3'd1, 32'h0};
      tbl[6] = '{64'h7E7E_7E7E_7EF8_0000, 8'h00, 6, int'(ACK), 3'd0, 32'h7E7E7E7E};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_dec_read", {31'd0, bus.dec_read}, 32'd0);
      chk("rst_enc_start", {31'd0, bus.enc_start}, 32'd0);
      chk("rst_enc_data", {24'd0, bus.enc_data}, 32'd0);
      chk("rst_frame_valid", {31'd0, bus.frame_valid}, 32'd0);
      chk("rst_frame_data", bus.frame_data, 32'd0);
      chk("rst_err_code", {29'd0, bus.err_code}, 32'd0);
      chk("rst_frame_cnt", {16'd0, bus.frame_cnt}, 32'd0);
      chk("rst_state", {29'd0, state_dbg}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         row_q(tbl[i], d, e);
         run_frame(d, e, tbl[i].n, tbl[i].rep, tbl[i].err, tbl[i].fr, 1'b0, $sformatf("row%0d", i));
      end
      wait_idle("table");

      // Timeout inside PAYLOAD, then a good frame must still be taken.
      send_pkt(SOF, 1'b0, 0);
      send_pkt(8'h01, 1'b0, 0);
      repeat (TIMEOUT / 2) @(posedge clk);
      #1;
      chk("to_early_err", {29'd0, bus.err_code}, {29'd0, last_err});
      chk("to_early_state", {29'd0, state_dbg}, 32'd1);
      repeat (TIMEOUT + 5) @(posedge clk);
      #1;
      chk("to_err_code", {29'd0, bus.err_code}, 32'd2);
      chk("to_state", {29'd0, state_dbg}, 32'd0);
      check_reply(NONE, "to");
      row_q(tbl[0], d, e);
      run_frame(d, e, tbl[0].n, tbl[0].rep, tbl[0].err, tbl[0].fr, 1'b0, "after_to");
      wait_idle("after_to");

      // Overflow with host stalled, then release and load on the same edge.
      host_mode = 0;
      row_q(tbl[0], d, e);
      run_frame(d, e, 6, int'(ACK), 3'd0, 32'h04030201, 1'b0, "ov_first");
      row_q(tbl[3], d, e);
      run_frame(d, e, 7, int'(NAK), 3'd4, 32'h0, 1'b0, "ov_second");
      chk("ov_frame_data", bus.frame_data, 32'h04030201);
      chk("ov_frame_valid", {31'd0, bus.frame_valid}, 32'd1);
      row_q(tbl[6], d, e);
      run_frame(d, e, 6, int'(ACK), 3'd0, 32'h7E7E7E7E, 1'b1, "same_cycle");
      wait_idle("same_cycle");
      chk("same_cycle_drained", exp_q.size(), 0);

      host_mode = 2;
      for (int i = 0; i < 40; i++) rand_frame(i);
      host_mode = 1;
      wait_idle("rand");

      // Reset in the middle of PAYLOAD discards the partial frame.
      send_pkt(SOF, 1'b0, 0);
      send_pkt(8'h01, 1'b0, 0);
      send_pkt(8'h02, 1'b0, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_rst_frame_valid", {31'd0, bus.frame_valid}, 32'd0);
      chk("mid_rst_frame_data", bus.frame_data, 32'd0);
      chk("mid_rst_err_code", {29'd0, bus.err_code}, 32'd0);
      chk("mid_rst_frame_cnt", {16'd0, bus.frame_cnt}, 32'd0);
      chk("mid_rst_enc_data", {24'd0, bus.enc_data}, 32'd0);
      chk("mid_rst_state", {29'd0, state_dbg}, 32'd0);
      exp_q.delete();
      exp_cnt = 16'd0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      row_q(tbl[0], d, e);
      run_frame(d, e, tbl[0].n, tbl[0].rep, tbl[0].err, tbl[0].fr, 1'b0, "post_rst");
      wait_idle("post_rst");
      chk("final_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
